// File: rtl/pdm_modulator.sv
// pdm_modulator: signed PCM -> 1-bit PDM delta-sigma modulator with ZOH upsampling.
// Define PDM_MOD2_EN for the second-order loop; the default build is first order.
module pdm_modulator #(
  parameter int I_BW    = 8,
  parameter int OSR     = 250,
  parameter int CLK_DIV = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [I_BW-1:0] data_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            pdm_o,
  output logic            pdm_valid_o,
  output logic            underrun_o
);

  localparam int DCW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BCW = (OSR > 2) ? $clog2(OSR) : 1;

  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(OSR - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic            clear;
  logic            accept;
  logic            tick;
  logic            boundary;

  logic [0:0]      state_q, state_d;
  logic [DCW-1:0]  div_q, div_d;
  logic [BCW-1:0]  bit_q, bit_d;
  logic [I_BW-1:0] cur_q, cur_d;
  logic [I_BW-1:0] nxt_q, nxt_d;
  logic            nxt_valid_q, nxt_valid_d;
  logic            pdm_q, pdm_d;
  logic            pdm_valid_q, pdm_valid_d;
  logic            underrun_q, underrun_d;

  assign clear    = rst_i | ~en_i;
  assign ready_o  = en_i & ~rst_i & ~nxt_valid_q;
  assign accept   = valid_i & ready_o;
  assign tick     = (state_q == S_RUN) && (div_q == DIV_LAST);
  assign boundary = tick && (bit_q == BIT_LAST);

  assign pdm_o       = pdm_q;
  assign pdm_valid_o = pdm_valid_q;
  assign underrun_o  = underrun_q;

  // Control: sample buffering, bit-rate divider and per-sample bit counter.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    nxt_valid_d = nxt_valid_q;
    underrun_d  = underrun_q;
    pdm_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cur_d   = data_i;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          pdm_valid_d = 1'b1;
          bit_d       = boundary ? '0 : bit_q + 1'b1;
        end
        // The boundary consumes the old pending sample before any new accept.
        if (boundary) begin
          if (nxt_valid_q) begin
            cur_d       = nxt_q;
            nxt_valid_d = 1'b0;
          end else begin
            underrun_d  = 1'b1;
          end
        end
        if (accept) begin
          nxt_d       = data_i;
          nxt_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; disable acts exactly like reset.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      pdm_q       <= 1'b0;
      pdm_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      nxt_valid_q <= nxt_valid_d;
      pdm_q       <= pdm_d;
      pdm_valid_q <= pdm_valid_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef PDM_MOD2_EN

  localparam int I1W = 12;
  localparam int I2W = 16;

  logic signed [I_BW-1:0]  x;
  logic signed [I_BW:0]    y;
  logic signed [I1W+1:0]   i1_sum;
  logic signed [I2W+1:0]   i2_sum;
  logic signed [I1W-1:0]   i1_new;
  logic signed [I1W-1:0]   i1_q, i1_d;
  logic signed [I2W-1:0]   i2_q, i2_d;
  logic                    sat_seen_q, sat_seen_d;
  logic                    ovf1, ovf2;

  function automatic logic [I1W-1:0] sat_i1(input logic [I1W+1:0] v);
    if (v[I1W+1:I1W-1] == 3'b000 || v[I1W+1:I1W-1] == 3'b111)
      return v[I1W-1:0];
    return v[I1W+1] ? {1'b1, {(I1W-1){1'b0}}} : {1'b0, {(I1W-1){1'b1}}};
  endfunction

  function automatic logic [I2W-1:0] sat_i2(input logic [I2W+1:0] v);
    if (v[I2W+1:I2W-1] == 3'b000 || v[I2W+1:I2W-1] == 3'b111)
      return v[I2W-1:0];
    return v[I2W+1] ? {1'b1, {(I2W-1){1'b0}}} : {1'b0, {(I2W-1){1'b1}}};
  endfunction

  assign x = cur_q;
  // Feedback is +half-scale when i2 is non-negative, else -half-scale.
  assign y = i2_q[I2W-1] ? {2'b11, {(I_BW-1){1'b0}}}
                         : {2'b01, {(I_BW-1){1'b0}}};

  assign i1_sum = (I1W+2)'(i1_q) + (I1W+2)'(x) - (I1W+2)'(y);
  assign i1_new = sat_i1(i1_sum);
  assign i2_sum = (I2W+2)'(i2_q) + (I2W+2)'(i1_new) - (I2W+2)'(y);

  assign ovf1 = (i1_sum[I1W+1:I1W-1] != 3'b000) && (i1_sum[I1W+1:I1W-1] != 3'b111);
  assign ovf2 = (i2_sum[I2W+1:I2W-1] != 3'b000) && (i2_sum[I2W+1:I2W-1] != 3'b111);

  // Second-order loop step; the bit is decided from i2 before its update.
  always_comb begin
    i1_d       = i1_q;
    i2_d       = i2_q;
    pdm_d      = pdm_q;
    sat_seen_d = sat_seen_q;
    if (tick) begin
      pdm_d      = ~i2_q[I2W-1];
      i1_d       = i1_new;
      i2_d       = sat_i2(i2_sum);
      sat_seen_d = sat_seen_q | ovf1 | ovf2;
    end
  end

  // Integrator state plus a sticky record of any saturation event.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      i1_q       <= '0;
      i2_q       <= '0;
      sat_seen_q <= 1'b0;
    end else begin
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      sat_seen_q <= sat_seen_d;
    end
  end

`else

  logic [I_BW-1:0] acc_q, acc_d;
  logic [I_BW-1:0] u;
  logic [I_BW:0]   sum;

  // Offset-binary view of the sample: 0 is mid-scale, full-scale negative is 0.
  assign u   = {~cur_q[I_BW-1], cur_q[I_BW-2:0]};
  assign sum = {1'b0, acc_q} + {1'b0, u};

  // Error-feedback step: carry out is the bit, remainder stays in acc.
  always_comb begin
    acc_d = acc_q;
    pdm_d = pdm_q;
    if (tick) begin
      acc_d = sum[I_BW-1:0];
      pdm_d = sum[I_BW];
    end
  end

  // Accumulator persists across sample boundaries; only clear resets it.
  always_ff @(posedge clk_i) begin
    if (clear) acc_q <= '0;
    else       acc_q <= acc_d;
  end

`endif

endmodule

// File: tb/tb_pdm_modulator.sv
// tb_pdm_modulator: scoreboard bench for pdm_modulator.
// Expected bits are queued on each accept and popped on every pdm_valid_o pulse.
`timescale 1ns/1ps
module tb_pdm_modulator;

  localparam int OSR     = 250;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       pdm_o;
  logic       pdm_valid_o;
  logic       underrun_o;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  bit   exp_q[$];
  int   bits_seen      = 0;
  int   ones_seen      = 0;
  int   last_pulse_cyc = 0;
  bit   mon_first      = 1'b1;
  logic first_bits [4];

`ifndef PDM_MOD2_EN
  logic [7:0] acc_m  = 8'h00;
  logic [7:0] last_s = 8'h00;
  bit         exp_bit;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pdm_modulator #(
    .I_BW(8),
    .OSR(OSR),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .en_i(en_i),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .pdm_o(pdm_o),
    .pdm_valid_o(pdm_valid_o),
    .underrun_o(underrun_o)
  );

`ifndef PDM_MOD2_EN
  function automatic void push_sample(input logic [7:0] s);
    logic [8:0] sum;
    for (int k = 0; k < OSR; k++) begin
      sum   = {1'b0, acc_m} + {2'b00, ~s[7], s[6:0]};
      exp_q.push_back(sum[8]);
      acc_m = sum[7:0];
    end
    last_s = s;
  endfunction
`endif

  initial forever begin
    @(negedge clk);
    if (pdm_valid_o === 1'b1) begin
      if (!mon_first) begin
        checks++;
        if (cyc - last_pulse_cyc !== CLK_DIV)
          $display("FAIL pulse_gap: got %0d cycles, want %0d", cyc - last_pulse_cyc, CLK_DIV);
        else passed++;
      end
      mon_first      = 1'b0;
      last_pulse_cyc = cyc;
`ifndef PDM_MOD2_EN
      if (exp_q.size() == 0) push_sample(last_s);
      exp_bit = exp_q.pop_front();
      checks++;
      if (pdm_o !== exp_bit)
        $display("FAIL pdm_bit[%0d]: got %b, want %b", bits_seen, pdm_o, exp_bit);
      else passed++;
`endif
      if (bits_seen < 4) first_bits[bits_seen] = pdm_o;
      bits_seen++;
      if (pdm_o === 1'b1) ones_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_model();
    exp_q.delete();
`ifndef PDM_MOD2_EN
    acc_m = 8'h00;
`endif
    bits_seen = 0;
    ones_seen = 0;
    mon_first = 1'b1;
  endtask

  task automatic do_clear();
    en_i    = 1'b0;
    valid_i = 1'b0;
    step();
    step();
    reset_model();
    en_i = 1'b1;
    step();
  endtask

  task automatic send(input logic [7:0] s, output int acc_cyc);
    int n = 0;
    valid_i = 1'b1;
    data_i  = s;
    while (ready_o !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (ready_o !== 1'b1) begin
      checks++;
      $display("FAIL send_timeout: ready_o=%b after %0d cycles", ready_o, n);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
`ifndef PDM_MOD2_EN
    push_sample(s);
`endif
    valid_i = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    int b = 0;
    while (bits_seen < n && b < n * CLK_DIV * 2 + 100) begin
      step();
      b++;
    end
    if (bits_seen < n) begin
      checks++;
      $display("FAIL wait_bits: got %0d bits, want %0d", bits_seen, n);
    end
  endtask

  task automatic test_reset();
    int t;
    rst_i   = 1'b1;
    en_i    = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h00;
    step();
    step();
    step();
    checks++;
    if (ready_o !== 1'b0) $display("FAIL rst_ready: got %b, want 0", ready_o);
    else passed++;
    checks++;
    if ({pdm_o, pdm_valid_o, underrun_o} !== 3'b000)
      $display("FAIL rst_outs: got %b, want 000", {pdm_o, pdm_valid_o, underrun_o});
    else passed++;
    checks++;
    if (bits_seen !== 0) $display("FAIL rst_no_bits: got %0d, want 0", bits_seen);
    else passed++;
    rst_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) $display("FAIL rst_release_ready: got %b, want 1", ready_o);
    else passed++;
    send(8'h00, t);
    wait_bits(1);
    checks++;
    if (last_pulse_cyc - t !== CLK_DIV)
      $display("FAIL first_latency: got %0d, want %0d", last_pulse_cyc - t, CLK_DIV);
    else passed++;
  endtask

  task automatic test_zero_underrun();
    wait_bits(4);
`ifndef PDM_MOD2_EN
    checks++;
    if ({first_bits[0], first_bits[1], first_bits[2], first_bits[3]} !== 4'b0101)
      $display("FAIL zero_pattern: got %b%b%b%b, want 0101",
               first_bits[0], first_bits[1], first_bits[2], first_bits[3]);
    else passed++;
`else
    checks++;
    if (first_bits[0] !== 1'b1) $display("FAIL mod2_first_bit: got %b, want 1", first_bits[0]);
    else passed++;
`endif
    wait_bits(249);
    checks++;
    if (underrun_o !== 1'b0) $display("FAIL underrun_early: got %b, want 0", underrun_o);
    else passed++;
    wait_bits(250);
    checks++;
    if (ones_seen < 124 || ones_seen > 126 ||
        (ones_seen != 125 && first_bits[0] === 1'b0))
      $display("FAIL zero_density: got %0d ones, want 125", ones_seen);
    else passed++;
    checks++;
    if (underrun_o !== 1'b1) $display("FAIL underrun_set: got %b, want 1", underrun_o);
    else passed++;
    wait_bits(260);
    checks++;
    if (underrun_o !== 1'b1) $display("FAIL underrun_sticky: got %b, want 1", underrun_o);
    else passed++;
  endtask

  task automatic test_clear_mid();
    int t;
    wait_bits(350);
    en_i = 1'b0;
    step();
    checks++;
    if ({pdm_valid_o, pdm_o, ready_o, underrun_o} !== 4'b0000)
      $display("FAIL clear_outs: got %b, want 0000", {pdm_valid_o, pdm_o, ready_o, underrun_o});
    else passed++;
    step();
    reset_model();
    en_i = 1'b1;
    step();
    send(8'h00, t);
    wait_bits(1);
    checks++;
    if (last_pulse_cyc - t !== CLK_DIV)
      $display("FAIL reen_latency: got %0d, want %0d", last_pulse_cyc - t, CLK_DIV);
    else passed++;
    checks++;
`ifndef PDM_MOD2_EN
    if (first_bits[0] !== 1'b0) $display("FAIL reen_first_bit: got %b, want 0", first_bits[0]);
`else
    if (first_bits[0] !== 1'b1) $display("FAIL reen_first_bit: got %b, want 1", first_bits[0]);
`endif
    else passed++;
  endtask

  task automatic test_density();
    int t;
    logic [7:0] s  [3];
    int         lo [3];
    int         hi [3];
`ifndef PDM_MOD2_EN
    s[0] = 8'h7F; lo[0] = 249; hi[0] = 249;
    s[1] = 8'h80; lo[1] = 0;   hi[1] = 0;
    s[2] = 8'h40; lo[2] = 187; hi[2] = 187;
`else
    s[0] = 8'h00; lo[0] = 124; hi[0] = 126;
    s[1] = 8'h7F; lo[1] = 248; hi[1] = 250;
    s[2] = 8'h40; lo[2] = 185; hi[2] = 190;
`endif
    for (int i = 0; i < 3; i++) begin
      do_clear();
      send(s[i], t);
      wait_bits(250);
      checks++;
      if (ones_seen < lo[i] || ones_seen > hi[i])
        $display("FAIL density[%02h]: got %0d ones, want %0d..%0d", s[i], ones_seen, lo[i], hi[i]);
      else passed++;
`ifdef PDM_MOD2_EN
      checks++;
      if (dut.sat_seen_q !== 1'b0)
        $display("FAIL mod2_sat[%02h]: got %b, want 0", s[i], dut.sat_seen_q);
      else passed++;
`endif
    end
  endtask

  task automatic test_back_to_back();
    int ta;
    int tb;
    int tc;
    int o250;
    int lo;
    int hi;
`ifndef PDM_MOD2_EN
    lo = 63; hi = 63;
`else
    lo = 60; hi = 65;
`endif
    do_clear();
    send(8'h40, ta);
    send(8'hC0, tb);
    checks++;
    if (tb - ta !== 1) $display("FAIL b2b_accept_b: got %0d, want 1", tb - ta);
    else passed++;
    step();
    checks++;
    if (ready_o !== 1'b0) $display("FAIL b2b_ready_low: got %b, want 0", ready_o);
    else passed++;
    wait_bits(249);
    checks++;
    if (ready_o !== 1'b0) $display("FAIL b2b_ready_249: got %b, want 0", ready_o);
    else passed++;
    send(8'h20, tc);
    o250 = ones_seen;
    checks++;
    if (bits_seen !== 250 || tc !== last_pulse_cyc + 1)
      $display("FAIL b2b_accept_c: got bits=%0d dc=%0d, want bits=250 dc=1",
               bits_seen, tc - last_pulse_cyc);
    else passed++;
    wait_bits(500);
    checks++;
    if (ones_seen - o250 < lo || ones_seen - o250 > hi)
      $display("FAIL b2b_density_b: got %0d ones, want %0d..%0d", ones_seen - o250, lo, hi);
    else passed++;
    checks++;
    if (underrun_o !== 1'b0) $display("FAIL b2b_no_underrun: got %b, want 0", underrun_o);
    else passed++;
    wait_bits(510);
    checks++;
    if (underrun_o !== 1'b0) $display("FAIL b2b_no_underrun_c: got %b, want 0", underrun_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_underrun();
    test_clear_mid();
    test_density();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pdm_modulator.md
Name: pdm_modulator

Overview:
- Inverse of the PDM decimation filter: converts a stream of signed 8b PCM samples (16kHz) into a 1-bit PDM bitstream (4MHz) using a first-order error-feedback delta-sigma modulator with zero-order-hold upsampling.
- Drives PDM stimulus back into the DFE for loopback and self-test.
- Can also drive an external PDM sink.

Parameters:
- I_BW, 8, PCM sample width (signed two's complement).
- OSR, 250, PDM bits emitted per PCM sample.
- CLK_DIV, 4, clk_i cycles per PDM bit (>=2).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, synchronous, active-high.
- en_i  input  1  block enable; low acts as synchronous clear.
- data_i  input  I_BW  signed PCM sample.
- valid_i  input  1  sample valid.
- ready_o  output  1  sample accepted on a cycle where valid_i & ready_o.
- pdm_o  output  1  PDM bit, registered, held between ticks.
- pdm_valid_o  output  1  one-cycle pulse marking a new pdm_o bit.
- underrun_o  output  1  sticky: a sample boundary arrived with no pending sample.

Behaviour:
- Clear condition:
  - clear = rst_i | !en_i; rst_i has priority.
  - On clear, all registers reset: pdm_o=0, pdm_valid_o=0, underrun_o=0, acc=0, div_cnt=0, bit_cnt=0, cur=0, nxt_valid=0, state=IDLE.
- Buffering:
  - Current sample register cur, plus one pending register nxt with nxt_valid.
  - ready_o = en_i & !rst_i & !nxt_valid (combinational).
- States:
  - IDLE: no ticks; pdm_valid_o=0; pdm_o holds 0. On accept, data_i loads directly into cur (bypassing nxt). Then div_cnt=0, bit_cnt=0, go to RUN.
  - RUN:
    - div_cnt counts 0..CLK_DIV-1 and wraps.
    - tick = (div_cnt==CLK_DIV-1).
    - An accept in RUN writes nxt and sets nxt_valid.
- Tick (RUN only), all registered, one cycle:
  - u = {~cur[I_BW-1], cur[I_BW-2:0]}, i.e. offset-binary 0..255.
  - sum = {1'b0,acc} + u (9b); pdm_o <= sum[8]; acc <= sum[7:0]; pdm_valid_o <= 1.
  - pdm_valid_o = 0 on all non-tick cycles.
- Sample boundary (tick with bit_cnt==OSR-1):
  - bit_cnt <= 0.
  - If nxt_valid: cur <= nxt, nxt_valid <= 0.
  - Otherwise cur holds (sample repeats) and underrun_o <= 1.
  - acc is never cleared at a boundary.
- Simultaneous accept and boundary, same cycle:
  - The boundary first consumes the old nxt.
  - This cannot collide with an accept: an accept needs nxt_valid=0, and a boundary with nxt_valid=0 is an underrun.
  - So an accept on a boundary cycle writes nxt and leaves nxt_valid=1.
- Latency: accept in IDLE at cycle t -> first pdm_valid_o at cycle t+CLK_DIV; thereafter one bit every CLK_DIV cycles.
- Density: ones per OSR bits = floor((u*OSR + acc_start)/256), i.e. within ±1 of u*OSR/256.
- underrun_o clears only via clear. RUN never returns to IDLE except via clear.

Optional Feature:
- Macro PDM_MOD2_EN.
- Defined: second-order modulator replaces the accumulator.
  - x = cur (signed 8b); y = +128 if i2>=0 else -128.
  - Emitted bit = (i2>=0), using i2 before the update.
  - i1 <= sat12(i1 + x - y); i2 <= sat16(i2 + i1_new - y).
  - Signed saturating 12b and 16b integrators, cleared by clear.
  - First bit after clear is 1.
- Undefined: first-order behaviour as above. Ports, handshake and timing are identical in both builds.

Test Plan:
- Sample 0 (u=128), CLK_DIV=4: pdm_o sequence 0,1,0,1,…; exactly 125 ones in first 250 bits; pdm_valid_o every 4 cycles; first pulse at accept+4.
- Sample +127 -> 249 ones in the first 250 bits. Sample -128 -> 250 zeros. Sample +64 (u=192) -> 187 ones (floor(250*192/256)=187, acc from 0).
- Back-to-back valid_i with samples A,B,C:
  - A accepted in IDLE; B accepted the next cycle; ready_o low until the boundary of A.
  - C accepted the cycle after bit 250's tick.
  - Bits 251-500 reflect B.
- Single sample only: after 250 bits, underrun_o=1 at the boundary tick; the sample repeats; underrun_o remains 1 until en_i low.
- en_i dropped mid-RUN at bit 100:
  - Next cycle pdm_valid_o=0, pdm_o=0, ready_o=0, underrun_o=0.
  - On re-enable the block is in IDLE and the first bit after a new accept of 0 is 0 (acc=0).
- rst_i asserted with en_i high and a valid sample present: no accept (ready_o=0), all outputs 0; deassert -> accept the next cycle.
- PDM_MOD2_EN: input 0 -> 125±1 ones per 250 bits; input +127 -> ≥248 ones; no integrator wrap (saturation flag check via hierarchy).
